rv32_icache_ctrl: RTL and testbench

Direct-mapped instruction cache controller between the core's fetch port and the backing code memory. It returns instructions one cycle after request on a hit. On a miss it holds the core with `stall` while it fills one line from the backing memory over a req/ack word handshake. This is the first cache stage of the system; the existing 32-bit code RAM becomes its backing store.

---
 rtl/rv32_icache_pkg.sv | 35 +++
 rtl/rv32_icache_line_store.sv | 52 +++++
 rtl/rv32_icache_ctrl.sv | 168 ++++++++++++++++
 tb/tb_rv32_icache_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32_icache_pkg.sv
// Shared types and address-field helpers for the rv32 instruction cache.
package rv32_icache_pkg;

  typedef enum logic [1:0] {RUN, FILL, RESPOND, INVAL} state_t;

  localparam int XLEN  = 32;
  localparam int OFF_W = 2;

  function automatic int word_bits(input int words);
    return $clog2(words);
  endfunction

  function automatic int index_bits(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_bits(input int lines, input int words);
    return XLEN - OFF_W - word_bits(words) - index_bits(lines);
  endfunction

  function automatic logic [XLEN-1:0] addr_word(input logic [XLEN-1:0] a, input int words);
    return (a >> OFF_W) & 32'(words - 1);
  endfunction

  function automatic logic [XLEN-1:0] addr_index(input logic [XLEN-1:0] a, input int lines,
                                                 input int words);
    return (a >> (OFF_W + word_bits(words))) & 32'(lines - 1);
  endfunction

  function automatic logic [XLEN-1:0] addr_tag(input logic [XLEN-1:0] a, input int lines,
                                               input int words);
    return a >> (OFF_W + word_bits(words) + index_bits(lines));
  endfunction

endpackage

// File: rtl/rv32_icache_line_store.sv
// Tag, valid and data arrays for the direct-mapped icache: combinational
// lookup, single-word write, tag/valid set and one-cycle valid clear.
module rv32_icache_line_store
  import rv32_icache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4,
  parameter int IDX_W = index_bits(LINES),
  parameter int WRD_W = word_bits(WORDS),
  parameter int TAG_W = tag_bits(LINES, WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] lu_idx,
  input  logic [WRD_W-1:0] lu_word,
  input  logic [TAG_W-1:0] lu_tag,
  output logic             hit,
  output logic [31:0]      rdata,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WRD_W-1:0] wr_word,
  input  logic [31:0]      wr_data,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_idx,
  input  logic [TAG_W-1:0] set_tag,
  input  logic             clr_all
);

  logic [LINES-1:0]                       valid_q;
  logic [LINES-1:0][TAG_W-1:0]            tag_q;
  logic [LINES-1:0][WORDS-1:0][31:0]      data_q;

  assign hit   = valid_q[lu_idx] && (tag_q[lu_idx] == lu_tag);
  assign rdata = data_q[lu_idx][lu_word];

  // Reset and clear-all take priority so an aborted or flushed fill never
  // leaves a line marked valid.
  always_ff @(posedge clk) begin
    if (rst)          valid_q <= '0;
    else if (clr_all) valid_q <= '0;
    else if (set_en)  valid_q[set_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (set_en) tag_q[set_idx] <= set_tag;
  end

  always_ff @(posedge clk) begin
    if (wr_en) data_q[wr_idx][wr_word] <= wr_data;
  end

endmodule

// File: rtl/rv32_icache_ctrl.sv
// Direct-mapped instruction cache controller with line fill over a word
// req/ack backing interface. Optional RV32_ICACHE_STATS_EN adds hit/miss counters.
module rv32_icache_ctrl
  import rv32_icache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  output logic [31:0] cpu_instr,
  output logic        cpu_valid,
  output logic        stall,
  input  logic        flush_i,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
`ifdef RV32_ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = index_bits(LINES);
  localparam int WRD_W = word_bits(WORDS);
  localparam int TAG_W = tag_bits(LINES, WORDS);

  state_t           state_q, state_d;
  logic [31:0]      miss_addr_q;
  logic [WRD_W-1:0] cnt_q;
  logic             pend_q;

  logic [IDX_W-1:0] cpu_idx, miss_idx, lu_idx;
  logic [WRD_W-1:0] cpu_word, miss_word, lu_word;
  logic [TAG_W-1:0] cpu_tag, miss_tag;
  logic             hit;
  logic [31:0]      rdata;
  logic             take_hit, take_miss, wr_en, set_en, clr_all;
  logic             cnt_last;

  assign cpu_idx   = IDX_W'(addr_index(cpu_addr, LINES, WORDS));
  assign cpu_word  = WRD_W'(addr_word(cpu_addr, WORDS));
  assign cpu_tag   = TAG_W'(addr_tag(cpu_addr, LINES, WORDS));
  assign miss_idx  = IDX_W'(addr_index(miss_addr_q, LINES, WORDS));
  assign miss_word = WRD_W'(addr_word(miss_addr_q, WORDS));
  assign miss_tag  = TAG_W'(addr_tag(miss_addr_q, LINES, WORDS));
  assign cnt_last  = (cnt_q == WRD_W'(WORDS - 1));

  // Outside RUN the lookup port is steered to the missed word so the fill's
  // final ack can forward it without a second read cycle.
  assign lu_idx  = (state_q == RUN) ? cpu_idx  : miss_idx;
  assign lu_word = (state_q == RUN) ? cpu_word : miss_word;

  rv32_icache_line_store #(
    .LINES (LINES),
    .WORDS (WORDS)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .lu_idx  (lu_idx),
    .lu_word (lu_word),
    .lu_tag  (cpu_tag),
    .hit     (hit),
    .rdata   (rdata),
    .wr_en   (wr_en),
    .wr_idx  (miss_idx),
    .wr_word (cnt_q),
    .wr_data (mem_rdata),
    .set_en  (set_en),
    .set_idx (miss_idx),
    .set_tag (miss_tag),
    .clr_all (clr_all)
  );

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    take_hit  = 1'b0;
    take_miss = 1'b0;
    wr_en     = 1'b0;
    set_en    = 1'b0;
    clr_all   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (flush_i) state_d = INVAL;
        else if (cpu_req) begin
          if (hit) take_hit = 1'b1;
          else begin
            take_miss = 1'b1;
            state_d   = FILL;
          end
        end
      end
      FILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {miss_tag, miss_idx, cnt_q, 2'b00};
        if (mem_ack) begin
          wr_en = 1'b1;
          if (cnt_last) begin
            set_en  = 1'b1;
            state_d = RESPOND;
          end
        end
      end
      RESPOND: state_d = (pend_q || flush_i) ? INVAL : RUN;
      INVAL: begin
        stall   = 1'b1;
        clr_all = 1'b1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      cpu_instr   <= '0;
      cpu_valid   <= 1'b0;
      pend_q      <= 1'b0;
      cnt_q       <= '0;
      miss_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cpu_valid <= 1'b0;
      if (take_hit) begin
        cpu_valid <= 1'b1;
        cpu_instr <= rdata;
      end
      if (take_miss) begin
        miss_addr_q <= cpu_addr;
        cnt_q       <= '0;
      end
      if (state_q == FILL) begin
        if (flush_i) pend_q <= 1'b1;
        if (mem_ack) begin
          cnt_q <= cnt_q + WRD_W'(1);
          // The missed word is either arriving now or already in the array.
          if (cnt_last) begin
            cpu_valid <= 1'b1;
            cpu_instr <= (cnt_q == miss_word) ? mem_rdata : rdata;
          end
        end
      end
      if (state_q == INVAL) pend_q <= 1'b0;
    end
  end

`ifdef RV32_ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (take_hit)  hit_count  <= hit_count + 32'd1;
      if (take_miss) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv32_icache_ctrl.sv
// Scoreboard bench for rv32_icache_ctrl: memory responder with variable ack
// gap, expected-instruction and expected-fill-address queues.
module tb_rv32_icache_ctrl;

  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        rst, cpu_req, flush_i, mem_ack;
  logic [31:0] cpu_addr, mem_rdata;
  logic [31:0] cpu_instr, mem_addr;
  logic        cpu_valid, stall, mem_req;
`ifdef RV32_ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int          n_chk = 0, n_fail = 0;
  int          ack_gap = 0, ack_cnt = 0;
  int          exp_hits = 0, exp_misses = 0;
  logic [15:0] ver = 16'h0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];

  rv32_icache_ctrl #(.LINES(16), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_instr (cpu_instr),
    .cpu_valid (cpu_valid),
    .stall     (stall),
    .flush_i   (flush_i),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef RV32_ICACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ {ver, 16'h0} ^ 32'h1357_9BDF;
  endfunction

  // Backing memory: acks after ack_gap idle cycles, checks fill address order
  // and that the address holds steady while waiting.
  initial begin
    int w;
    logic [31:0] hold;
    w = 0; hold = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req) begin
        if (w > 0) check("maddr_stable", mem_addr, hold);
        hold = mem_addr;
        if (w == ack_gap) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word(mem_addr);
          ack_cnt++;
          w = 0;
          if (exp_addr_q.size() == 0) check("maddr_unexp", 32'd1, 32'd0);
          else check("maddr", mem_addr, exp_addr_q.pop_front());
        end else w++;
      end else w = 0;
    end
  end

  // Response monitor.
  initial forever begin
    @(negedge clk);
    if (cpu_valid) begin
      if (exp_q.size() == 0) check("unexp_valid", 32'd1, 32'd0);
      else check("instr", cpu_instr, exp_q.pop_front());
    end
  end

  task automatic fetch(input logic [31:0] a, input bit exp_hit, input int gap, input int flush_at);
    int cyc, st, a0, lat;
    logic [31:0] base;
    ack_gap = gap;
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_addr = a;
    exp_q.push_back(mem_word(a));
    base = a & ~32'(WORDS * 4 - 1);
    if (!exp_hit) begin
      for (int i = 0; i < WORDS; i++) exp_addr_q.push_back(base + 32'(4 * i));
      exp_misses++;
    end else exp_hits++;
    a0 = ack_cnt; st = 0; cyc = 0;
    lat = exp_hit ? 1 : 1 + WORDS * (gap + 1);
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      cpu_req = 1'b0;
      flush_i = (cyc == flush_at);
      if (stall) st++;
      if (cpu_valid) break;
    end
    flush_i = 1'b0;
    check("latency", 32'(cyc), 32'(lat));
    check("acks", 32'(ack_cnt - a0), exp_hit ? 32'd0 : 32'(WORDS));
    check("stall_cycles", 32'(st), exp_hit ? 32'd0 : 32'(WORDS * (gap + 1)));
  endtask

  task automatic check_stats();
`ifdef RV32_ICACHE_STATS_EN
    check("hit_count", hit_count, 32'(exp_hits));
    check("miss_count", miss_count, 32'(exp_misses));
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cpu_req = 1'b0; flush_i = 1'b0; cpu_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_instr", cpu_instr, 32'd0);
    check("rst_valid", {31'd0, cpu_valid}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check_stats();
    rst = 1'b0;

    fetch(32'h0000_0000, 1'b0, 0, -1);
    fetch(32'h0000_0008, 1'b1, 0, -1);
    ver = 16'h1;
    fetch(32'h0000_0100, 1'b0, 0, -1);
    fetch(32'h0000_0104, 1'b1, 0, -1);
    fetch(32'h0000_0000, 1'b0, 0, -1);

    fetch(32'h0000_2040, 1'b0, 3, -1);
    fetch(32'h0000_204C, 1'b1, 0, -1);

    // Flush alongside a cached request: no response, one INVAL cycle.
    @(negedge clk);
    flush_i = 1'b1; cpu_req = 1'b1; cpu_addr = 32'h0000_204C;
    @(negedge clk);
    flush_i = 1'b0; cpu_req = 1'b0;
    check("inval_stall", {31'd0, stall}, 32'd1);
    check("inval_valid", {31'd0, cpu_valid}, 32'd0);
    @(negedge clk);
    check("post_inval_stall", {31'd0, stall}, 32'd0);
    fetch(32'h0000_204C, 1'b0, 0, -1);

    // Flush during a fill: word still delivered, then INVAL.
    fetch(32'h0000_3000, 1'b0, 0, 2);
    @(negedge clk);
    check("pend_inval_stall", {31'd0, stall}, 32'd1);
    fetch(32'h0000_3000, 1'b0, 0, -1);
    check_stats();

    // Reset after two acks aborts the fill.
    ack_gap = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 32'h0000_0000;
    for (int i = 0; i < WORDS; i++) exp_addr_q.push_back(32'(4 * i));
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_mem_req", {31'd0, mem_req}, 32'd0);
    check("abort_stall", {31'd0, stall}, 32'd0);
    check("abort_valid", {31'd0, cpu_valid}, 32'd0);
    exp_addr_q.delete();
    exp_hits = 0; exp_misses = 0;
    check_stats();
    fetch(32'h0000_0000, 1'b0, 0, -1);
    fetch(32'h0000_0004, 1'b1, 0, -1);
    check_stats();

    repeat (3) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("exp_addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
